// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N producers, the stream_mux_rr mux and a single consumer.
// master = producer/consumer environment side, slave = the multiplexer.
interface stream_mux_rr_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
);
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [SW-1:0]   out_ch;
  logic            out_ready;

  modport master (
    output mode, sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel W-bit stream mux: round-robin or explicit select, registered output.
// Optional packet locking when STREAM_MUX_PKT_LOCK_EN is defined.
module stream_mux_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input logic clk,
  input logic rst_n,
  stream_mux_rr_if.slave bus
);
  localparam logic [SW:0]   NV      = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N-1);

  logic [W-1:0]  ch_data [N];
  logic [SW-1:0] rr_ptr;
  logic [N-1:0]  rr_grant, fix_grant, grant;
  logic [SW-1:0] rr_id, fix_id, gnt_id;
  logic          rr_found;
  logic [SW:0]   scan_idx;
  logic          can_load, xfer, advance;

  logic          vld_p1;
  logic [W-1:0]  data_p1;
  logic          last_p1;
  logic [SW-1:0] ch_p1;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] c);
    return (c == LAST_CH) ? '0 : c + 1'b1;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign ch_data[gi] = bus.in_data[gi*W +: W];
  end

  // Round-robin scan starting at rr_ptr, wrapping modulo N
  always_comb begin
    rr_grant = '0;
    rr_id    = '0;
    rr_found = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = {1'b0, rr_ptr} + (SW+1)'(i);
      if (scan_idx >= NV) scan_idx = scan_idx - NV;
      if (!rr_found && bus.in_valid[scan_idx[SW-1:0]]) begin
        rr_found                     = 1'b1;
        rr_id                        = scan_idx[SW-1:0];
        rr_grant[scan_idx[SW-1:0]]   = 1'b1;
      end
    end
  end

  // Out-of-range select is rejected before in_valid is indexed
  always_comb begin
    fix_grant = '0;
    fix_id    = bus.sel;
    if ({1'b0, bus.sel} < NV) begin
      if (bus.in_valid[bus.sel]) fix_grant[bus.sel] = 1'b1;
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic          locked;
  logic [SW-1:0] lock_ch;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    if (locked) begin
      gnt_id = lock_ch;
      if (bus.in_valid[lock_ch]) grant[lock_ch] = 1'b1;
    end else if (bus.mode) begin
      grant  = fix_grant;
      gnt_id = fix_id;
    end else begin
      grant  = rr_grant;
      gnt_id = rr_id;
    end
  end

  assign advance = bus.in_last[gnt_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      locked  <= ~bus.in_last[gnt_id];
      lock_ch <= gnt_id;
    end
  end
`else
  always_comb begin
    grant  = bus.mode ? fix_grant : rr_grant;
    gnt_id = bus.mode ? fix_id : rr_id;
  end

  assign advance = 1'b1;
`endif

  assign can_load     = ~vld_p1 | bus.out_ready;
  assign bus.in_ready = grant & {N{can_load & rst_n}};
  assign xfer         = |bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer && !bus.mode && advance) begin
      rr_ptr <= wrap_inc(gnt_id);
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      ch_p1   <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= ch_data[gnt_id];
      last_p1 <= bus.in_last[gnt_id];
      ch_p1   <= gnt_id;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_ch    = ch_p1;
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor of the 4:1 single-bit combinational mux: N-channel, W-bit streaming multiplexer with valid/ready handshakes.
- Two selection modes: round-robin arbitration or explicit select; output is registered.
- Sits between multiple producer streams and a single consumer.
- Replaces hand-written fixed-width muxes where back-pressure and fairness are required.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel.
- SW, $clog2(N), width of select and channel-id fields.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- mode  input  1  0 = round-robin arbitration, 1 = fixed select via sel.
- sel  input  SW  channel index used when mode=1.
- in_valid  input  N  per-channel valid.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_last  input  N  per-channel end-of-packet marker.
- in_ready  output  N  per-channel ready; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered data.
- out_last  output  1  registered last flag.
- out_ch  output  SW  source channel of the current output beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_last=0, out_ch=0, rr_ptr=0, lock state cleared. in_ready is all zero while in reset.
- Output register:
  - can_load = ~out_valid | out_ready.
  - An input transfer occurs on channel g when in_valid[g] & in_ready[g].
  - Transfer in a cycle: the register loads data, last and ch=g, and out_valid=1 next cycle.
  - out_ready with no transfer: out_valid clears.
  - Otherwise the register holds its value.
  - Latency: 1 cycle input to output. Full throughput is one beat per cycle when out_ready is held high.
- Grant (combinational, at most one bit set): in_ready = grant & {N{can_load}}.
- mode=0, round robin:
  - Scan channels rr_ptr, rr_ptr+1, …, wrapping modulo N.
  - The first channel with in_valid=1 gets the grant.
  - After a transfer from channel g, rr_ptr <= (g+1) mod N; wrap from N-1 goes to 0.
  - No transfer: rr_ptr is unchanged.
- mode=1, fixed select:
  - grant = one-hot(sel) if sel<N and in_valid[sel]; otherwise zero.
  - sel>=N grants nothing and never causes an out-of-range read.
  - rr_ptr is unchanged in this mode.
- Mode or sel changes take effect the same cycle; a beat already in the output register is unaffected.
- Back-pressure: while out_valid=1 and out_ready=0, out_data, out_last and out_ch hold stable and all in_ready are 0.
- All in_valid=0: no grant, and out_valid drops after the pending beat is consumed.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - A transfer with in_last=0 locks the grant to that channel. Arbitration and mode/sel are ignored for grant purposes.
  - The lock persists until a transfer from that channel with in_last=1.
  - rr_ptr advances only on a last-beat transfer.
  - While locked, other channels get in_ready=0 even if the locked channel is idle.
  - Reset clears the lock.
- Not defined:
  - Arbitration is per beat; in_last is only passed through to out_last.

Test Plan:
- Reset and hold: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately; after release, first grant starts at ch0.
- Round-robin fairness: N=4, mode=0, all in_valid=1, in_data ch i = 8'hA0+i, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; out_ch 0,1,2,3,0.
- Sparse round robin with wrap: only ch1 and ch3 valid, rr_ptr=2 -> grant order ch3, ch1, ch3.
- Fixed select: mode=1, sel=2, in_data ch2=8'h5C, valid on all channels -> only in_ready[2]=1; out_data=5C one cycle later. Then sel=3 with in_valid[3]=0 -> in_ready=0 and out_valid falls after consumption.
- Back-pressure: out_ready=0 for 3 cycles with a beat held -> out_data stable and in_ready=0. Raising out_ready -> next beat loads in the same cycle with no bubble.
- Packet lock (macro defined): ch0 sends 3 beats with last on beat 3 while ch1 is valid throughout -> ch1 not granted until after ch0's last beat; then ch1 is granted next.
